intval_stats: RTL and testbench

- Downstream consumer of the four-phase interval counter. Captures each completed `intval_cnt` measurement, which arrives flagged by `cnt_valid` from the `sig_a` domain.
- Accumulates 2^LOG2_NAVG measurements and reports mean, minimum and maximum to the readout logic through a valid/ready handshake.
- Runs entirely on `clk_0`.

---
 rtl/intval_pkg.sv | 16 +
 rtl/sync_fall_det.sv | 23 ++
 rtl/intval_stats.sv | 104 ++++++++++
 tb/tb_intval_stats.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/intval_pkg.sv
// Shared types and helpers for the interval statistics block.
package intval_pkg;

   localparam int CNT_WIDTH_DEF = 32;

   typedef enum logic {
      WAIT_HI = 1'b0,
      WAIT_LO = 1'b1
   } cap_state_e;

   // Accumulator is wide enough to hold 2^log2_navg full-scale samples.
   function automatic int acc_width(input int cnt_width, input int log2_navg);
      return cnt_width + log2_navg;
   endfunction

endpackage

// File: rtl/sync_fall_det.sv
// Multi-flop synchronizer for a sig_a-domain flag plus a falling-edge detector.
module sync_fall_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_0,
   input  logic rst,
   input  logic din,
   output logic v_s,
   output logic cap
);

   // [SYNC_STAGES-1:0] is the synchronizer; the top bit is the delayed copy.
   logic [SYNC_STAGES:0] vld_pipe;

   always_ff @(posedge clk_0) begin
      if (rst) vld_pipe <= '0;
      else     vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], din};
   end

   assign v_s = vld_pipe[SYNC_STAGES-1];
   assign cap = vld_pipe[SYNC_STAGES] & ~vld_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/intval_stats.sv
// Batches interval-counter measurements and reports mean/min/max through a
// valid/ready output register with a sticky overrun flag.
module intval_stats
   import intval_pkg::*;
#(
   parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
   parameter int LOG2_NAVG   = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk_0,
   input  logic                 rst,
   input  logic [CNT_WIDTH-1:0] intval_cnt,
   input  logic                 cnt_valid,
   input  logic                 clr,
   output logic [CNT_WIDTH-1:0] res_mean,
   output logic [CNT_WIDTH-1:0] res_min,
   output logic [CNT_WIDTH-1:0] res_max,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic                 overrun,
   output logic [LOG2_NAVG:0]   sample_idx
);

   localparam int ACC_W = acc_width(CNT_WIDTH, LOG2_NAVG);
   localparam int IW    = LOG2_NAVG + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'((1 << LOG2_NAVG) - 1);

   logic                 v_s, cap;
   cap_state_e           state, state_nx;
   logic [ACC_W-1:0]     acc, acc_sum;
   logic [CNT_WIDTH-1:0] run_min, run_max, min_nx, max_nx;
   logic                 rec, last, can_load;

   sync_fall_det #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_0 (clk_0),
      .rst   (rst),
      .din   (cnt_valid),
      .v_s   (v_s),
      .cap   (cap)
   );

   always_ff @(posedge clk_0) begin
      if (rst) state <= WAIT_HI;
      else     state <= state_nx;
   end

   // A falling edge only counts once a high phase has been seen in WAIT_HI.
   always_comb begin
      state_nx = state;
      case (state)
         WAIT_HI: if (v_s) state_nx = WAIT_LO;
         WAIT_LO: if (cap) state_nx = WAIT_HI;
         default: state_nx = WAIT_HI;
      endcase
      if (clr) state_nx = WAIT_HI;
   end

   assign rec      = (state == WAIT_LO) & cap & ~clr;
   assign last     = rec & (sample_idx == LAST_IDX);
   assign can_load = ~res_valid | res_ready;
   assign acc_sum  = acc + ACC_W'(intval_cnt);
   assign min_nx   = (intval_cnt < run_min) ? intval_cnt : run_min;
   assign max_nx   = (intval_cnt > run_max) ? intval_cnt : run_max;

   always_ff @(posedge clk_0) begin
      if (rst || clr || last) begin
         acc        <= '0;
         run_min    <= '1;
         run_max    <= '0;
         sample_idx <= '0;
      end else if (rec) begin
         acc        <= acc_sum;
         run_min    <= min_nx;
         run_max    <= max_nx;
         sample_idx <= sample_idx + IW'(1);
      end
   end

   // The final sample feeds the result directly rather than via acc/min/max.
   always_ff @(posedge clk_0) begin
      if (rst) begin
         res_mean  <= '0;
         res_min   <= '0;
         res_max   <= '0;
         res_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (last && can_load) begin
            res_mean  <= acc_sum[ACC_W-1:LOG2_NAVG];
            res_min   <= min_nx;
            res_max   <= max_nx;
            res_valid <= 1'b1;
         end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end

         if (clr)                      overrun <= 1'b0;
         else if (last && !can_load)   overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_intval_stats.sv
// Directed plus randomized bench for intval_stats against a batch-level model.
module tb_intval_stats;

   localparam int CW = 32;
   localparam int L  = 2;
   localparam int SS = 2;
   localparam int N  = 1 << L;

   logic          clk_0 = 1'b0;
   logic          rst = 1'b1;
   logic [CW-1:0] intval_cnt = '0;
   logic          cnt_valid = 1'b1;
   logic          clr = 1'b0;
   logic          res_ready = 1'b0;
   logic          rdy1 = 1'b1;
   logic [CW-1:0] res_mean, res_min, res_max;
   logic          res_valid, overrun;
   logic [L:0]    sample_idx;
   logic [CW-1:0] m1_mean, m1_min, m1_max;
   logic          m1_valid, m1_ovr;
   logic [0:0]    m1_idx;

   int total = 0;
   int bad   = 0;

   // model state
   logic [CW-1:0] mq[$];
   logic          m_valid = 0, m_ovr = 0;
   logic [CW-1:0] m_mean = 0, m_min = 0, m_max = 0;

   always #5 clk_0 = ~clk_0;

   intval_stats #(.CNT_WIDTH(CW), .LOG2_NAVG(L), .SYNC_STAGES(SS)) u_dut (
      .clk_0(clk_0), .rst(rst), .intval_cnt(intval_cnt), .cnt_valid(cnt_valid),
      .clr(clr), .res_mean(res_mean), .res_min(res_min), .res_max(res_max),
      .res_valid(res_valid), .res_ready(res_ready), .overrun(overrun),
      .sample_idx(sample_idx));

   intval_stats #(.CNT_WIDTH(CW), .LOG2_NAVG(0), .SYNC_STAGES(SS)) u_dut1 (
      .clk_0(clk_0), .rst(rst), .intval_cnt(intval_cnt), .cnt_valid(cnt_valid),
      .clr(clr), .res_mean(m1_mean), .res_min(m1_min), .res_max(m1_max),
      .res_valid(m1_valid), .res_ready(rdy1), .overrun(m1_ovr),
      .sample_idx(m1_idx));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_rec(input logic [CW-1:0] v, input logic rdy);
      longint unsigned s;
      logic [CW-1:0] mn, mx;
      mq.push_back(v);
      if (mq.size() == N) begin
         s = 0; mn = '1; mx = '0;
         foreach (mq[i]) begin
            s += longint'(mq[i]);
            if (mq[i] < mn) mn = mq[i];
            if (mq[i] > mx) mx = mq[i];
         end
         if (!m_valid || rdy) begin
            m_mean = CW'(s / N); m_min = mn; m_max = mx; m_valid = 1;
         end else begin
            m_ovr = 1;
         end
         mq.delete();
      end else if (rdy) begin
         m_valid = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, res_valid, m_valid);
      chk({tag, ".mean"},  res_mean,  m_mean);
      chk({tag, ".min"},   res_min,   m_min);
      chk({tag, ".max"},   res_max,   m_max);
      chk({tag, ".ovr"},   overrun,   m_ovr);
      chk({tag, ".idx"},   sample_idx, 64'(mq.size()));
   endtask

   // One upstream window; rdy/clr_cap are applied in the capture cycle.
   task automatic window(input logic [CW-1:0] v, input logic rdy, input logic clr_cap);
      @(negedge clk_0);
      intval_cnt = v;
      cnt_valid  = 1;
      repeat (3) @(negedge clk_0);
      cnt_valid = 0;
      repeat (SS) @(negedge clk_0);
      chk("cap_cycle.valid", res_valid, m_valid);
      res_ready = rdy;
      clr       = clr_cap;
      if (clr_cap) begin
         mq.delete(); m_ovr = 0;
      end else begin
         model_rec(v, rdy);
      end
      @(negedge clk_0);
      res_ready = 0;
      clr       = 0;
      check_all("win");
      if (!clr_cap) begin
         chk("n1.valid", m1_valid, 1);
         chk("n1.mean", m1_mean, v);
         chk("n1.min",  m1_min,  v);
         chk("n1.max",  m1_max,  v);
         chk("n1.idx",  m1_idx,  0);
      end
      repeat (2) @(negedge clk_0);
   endtask

   task automatic consume();
      @(negedge clk_0);
      res_ready = 1;
      m_valid   = 0;
      @(negedge clk_0);
      res_ready = 0;
      check_all("consume");
   endtask

   task automatic do_clr();
      @(negedge clk_0);
      clr = 1;
      mq.delete(); m_ovr = 0;
      @(negedge clk_0);
      clr = 0;
      check_all("clr");
   endtask

   task automatic do_rst();
      @(negedge clk_0);
      rst = 1;
      mq.delete(); m_valid = 0; m_ovr = 0; m_mean = 0; m_min = 0; m_max = 0;
      @(negedge clk_0);
      check_all("in_rst");
      chk("in_rst.n1valid", m1_valid, 0);
      @(negedge clk_0);
      rst = 0;
   endtask

   initial begin
      logic [CW-1:0] v;
      logic r;
      // reset with cnt_valid high; flag drops before reset releases
      repeat (3) @(negedge clk_0);
      check_all("reset");
      chk("reset.n1valid", m1_valid, 0);
      cnt_valid = 0;
      @(negedge clk_0);
      rst = 0;
      repeat (6) @(negedge clk_0);
      check_all("post_rst");
      chk("post_rst.n1valid", m1_valid, 0);

      // basic batch
      window(100, 0, 0); window(104, 0, 0); window(96, 0, 0); window(108, 0, 0);
      chk("b1.mean", res_mean, 102);
      consume();

      // truncation
      window(1, 0, 0); window(2, 0, 0); window(2, 0, 0); window(2, 0, 0);
      chk("b2.mean", res_mean, 1);
      consume();

      // overrun
      repeat (4) window(10, 0, 0);
      repeat (4) window(20, 0, 0);
      chk("ovr.mean", res_mean, 10);
      chk("ovr.flag", overrun, 1);
      consume();
      chk("ovr.cons", res_valid, 0);
      do_clr();
      chk("ovr.clr", overrun, 0);

      // ready coincident with completion
      repeat (4) window(5, 0, 0);
      repeat (3) window(7, 0, 0);
      window(7, 1, 0);
      chk("coin.mean", res_mean, 7);
      chk("coin.valid", res_valid, 1);
      chk("coin.ovr", overrun, 0);
      consume();

      // full-scale samples with clr in between
      repeat (2) window(32'hFFFF_FFFF, 0, 0);
      do_clr();
      chk("fs.idx", sample_idx, 0);
      repeat (4) window(32'hFFFF_FFFF, 0, 0);
      chk("fs.mean", res_mean, 32'hFFFF_FFFF);
      consume();

      // reset mid-batch
      repeat (3) window(900, 0, 0);
      do_rst();
      repeat (4) window(50, 0, 0);
      chk("rst.mean", res_mean, 50);
      consume();

      // clr coincident with a capture discards that sample
      window(3, 0, 0); window(3, 0, 0);
      window(999, 0, 1);
      chk("clrcap.idx", sample_idx, 0);
      repeat (4) window(9, 0, 0);
      consume();

      // randomized batches
      for (int b = 0; b < 6; b++) begin
         for (int k = 0; k < N; k++) begin
            v = ($urandom_range(0, 1) == 1) ? CW'($urandom) : CW'($urandom_range(0, 1000));
            r = ($urandom_range(0, 3) == 0);
            window(v, r, 0);
         end
         if ($urandom_range(0, 1) == 1) consume();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
